shift_add_scaler: RTL and testbench
===================================

Name: shift_add_scaler

Overview:
- Parametrised, pipelined constant-coefficient scaler for the adaptive-filter datapath, used for step-size (mu) and error scaling.
- Multiplies a signed sample by a runtime-programmable coefficient in (-1, 1), built as a signed sum of powers of two (shift-add, no multiplier).
- Three-stage pipeline with valid/ready flow control, round-half-up rounding and output saturation.
- Sits between the error computation and the coefficient-update logic.

Parameters:
- IN_W, 33, input sample width, signed two's complement.
- OUT_W, 33, output width, signed; saturation applies when the result exceeds it.
- MAX_SHIFT, 8, number of coefficient terms; term k (1..MAX_SHIFT) weighs 2^-k.
- POS_RST, 8'h16, reset value of the positive mask (0.40625 = 2^-2 + 2^-3 + 2^-5).
- NEG_RST, 8'h00, reset value of the negative mask.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  load cfg_pos/cfg_neg into the coefficient register
- cfg_pos  in  MAX_SHIFT  bit k-1 set: add x*2^-k
- cfg_neg  in  MAX_SHIFT  bit k-1 set: subtract x*2^-k
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_data  in  IN_W  signed sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  signed scaled result
- out_sat  out  1  out_data was clipped (qualifies out_data)

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valids clear; out_valid=0, out_data=0, out_sat=0.
  - Coefficient register becomes POS_RST/NEG_RST.
  - A reset asserted mid-stream discards in-flight samples without emitting them.
- Coefficient register:
  - cfg_we=1 at edge t loads the new masks; samples accepted at edge t+1 onward use them.
  - A sample accepted in the same cycle as cfg_we uses the old value.
  - The coefficient travels with each sample, so in-flight samples are unaffected by later writes.
  - A bit set in both masks contributes 0.
- Arithmetic is exact until stage 3:
  - x_ext = in_data * 2^MAX_SHIFT, sign-extended to SUM_W = IN_W + MAX_SHIFT + 1 + clog2(MAX_SHIFT).
  - term_k = x_ext >>> k. This is exact because the fractional bits are kept.
  - Each term is added if its pos bit is set and subtracted if its neg bit is set.
  - Rounding: r = (sum + 2^(MAX_SHIFT-1)) >>> MAX_SHIFT, i.e. floor(v + 0.5); ties go toward +inf (-0.5 -> 0).
  - Saturation to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when r is clipped.
- Pipeline stages:
  - S1 registers the sample and its coefficient masks.
  - S2 registers the signed partial terms, summed as a pair-wise tree within S2.
  - S3 registers the rounded, saturated result and the sat flag.
  - Latency is 3 cycles from acceptance to out_valid with no stall; throughput is 1 sample/cycle.
- Flow control:
  - ready_3 = !v3 | out_ready
  - ready_2 = !v2 | ready_3
  - ready_1 = !v1 | ready_2
  - in_ready = ready_1
  - A stage loads only when its ready is high. Acceptance occurs when in_valid & in_ready.
  - While out_valid & !out_ready, out_data and out_sat hold stable and no sample is lost or duplicated.
  - A full pipeline with out_ready=0 drives in_ready=0. Bubbles collapse when downstream is stalled.
- No internal state machine beyond the per-stage valid bits; in_ready has a combinational path from out_ready.

Decomposition:
- Package scaler_pkg:
  - SUM_W calculation function.
  - Round-half-up/saturate function.
  - Typedef of the coefficient mask pair.
- Sub-module shift_term (combinational): given x_ext, k, pos, neg, returns the signed term. It is instantiated MAX_SHIFT times in a generate loop.

Test Plan:
- Reset masks (0x16), in_data=1000 -> out_data=406 exactly 3 cycles after acceptance, out_sat=0. With in_data=-1000 -> -406.
- cfg_pos=0x02 (0.25), in_data=2 -> 1. in_data=-2 -> 0 (tie rounds toward +inf).
- OUT_W=16, cfg_pos=0x01 (0.5), in_data=2^20 -> 32767, out_sat=1. in_data=-2^20 -> -32768, out_sat=1.
- cfg_pos=0x01, cfg_neg=0x04 (0.5 - 0.125), in_data=800 -> 300. Both masks 0x01 -> 0.
- Stream of 10 back-to-back samples with out_ready low for cycles 4-7 -> in_ready drops once the pipeline is full; all 10 results arrive in order with none lost or duplicated; out_data stays stable while stalled.
- cfg_we pulsed in the same cycle a sample is accepted -> that sample uses the old coefficient and the next sample uses the new one. Assert rst with 3 samples in flight -> out_valid=0 next cycle and the in-flight samples are never emitted.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared types and helpers for the shift-add scaler: coefficient mask pair,
// accumulator width calculation and the round-half-up / saturate step.
package scaler_pkg;

   // Widest coefficient the mask pair can describe.
   localparam int MAX_TERMS = 16;
   // Working width used by the rounding helper; any scaler accumulator fits.
   localparam int MAXW = 128;

   typedef struct packed {
      logic [MAX_TERMS-1:0] pos;
      logic [MAX_TERMS-1:0] neg;
   } coef_t;

   typedef struct packed {
      logic [MAXW-1:0] data;
      logic            sat;
   } rs_t;

   // Accumulator width: sample, fractional bits, sign guard and growth of the term sum.
   function automatic int sum_w(input int in_w, input int max_shift);
      return in_w + max_shift + 32'sd1 + $clog2(max_shift);
   endfunction

   // Drops frac fractional bits with floor(v + 0.5), then clips to out_w signed bits.
   function automatic rs_t round_sat(input logic signed [MAXW-1:0] sum,
                                     input int frac,
                                     input int out_w);
      logic signed [MAXW-1:0] one_v;
      logic signed [MAXW-1:0] half_v;
      logic signed [MAXW-1:0] r_v;
      logic signed [MAXW-1:0] hi_v;
      logic signed [MAXW-1:0] lo_v;
      rs_t                    res_v;
      one_v  = {{(MAXW-1){1'b0}}, 1'b1};
      half_v = one_v <<< (frac - 32'sd1);
      r_v    = (sum + half_v) >>> frac;
      hi_v   = (one_v <<< (out_w - 32'sd1)) - one_v;
      lo_v   = ~hi_v;
      if (r_v > hi_v) begin
         res_v.data = hi_v;
         res_v.sat  = 1'b1;
      end else if (r_v < lo_v) begin
         res_v.data = lo_v;
         res_v.sat  = 1'b1;
      end else begin
         res_v.data = r_v;
         res_v.sat  = 1'b0;
      end
      return res_v;
   endfunction

endpackage

// File: rtl/shift_term.sv
// One coefficient term: +/- x_ext * 2^-K, or zero when the term is off
// or enabled in both masks.
module shift_term #(
   parameter int SUM_W = 45,
   parameter int K     = 1
) (
   input  logic signed [SUM_W-1:0] x_ext,
   input  logic                    pos,
   input  logic                    neg,
   output logic signed [SUM_W-1:0] term
);

   logic signed [SUM_W-1:0] shifted_s;

   // Select the signed contribution of this power of two.
   always_comb begin
      shifted_s = x_ext >>> K;
      case ({pos, neg})
         2'b10:   term = shifted_s;
         2'b01:   term = -shifted_s;
         default: term = '0;
      endcase
   end

endmodule

// File: rtl/shift_add_scaler.sv
// Three-stage multiplier-free scaler: out = round(in * sum(+/-2^-k)) with
// saturation and valid/ready flow control. The coefficient rides along with
// each sample so later writes never disturb samples already in flight.
module shift_add_scaler
   import scaler_pkg::*;
#(
   parameter int                   IN_W      = 33,
   parameter int                   OUT_W     = 33,
   parameter int                   MAX_SHIFT = 8,
   parameter logic [MAX_SHIFT-1:0] POS_RST   = 8'h16,
   parameter logic [MAX_SHIFT-1:0] NEG_RST   = 8'h00
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [MAX_SHIFT-1:0]    cfg_pos,
   input  logic [MAX_SHIFT-1:0]    cfg_neg,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat
);

   localparam int    SUM_W    = sum_w(IN_W, MAX_SHIFT);
   localparam int    NP       = 32'sd2 ** $clog2(MAX_SHIFT);
   localparam coef_t COEF_RST = '{pos: MAX_TERMS'(POS_RST), neg: MAX_TERMS'(NEG_RST)};

   coef_t                   coef_r;
   coef_t                   coef_wr_s;
   logic                    ready1_s;
   logic                    ready2_s;
   logic                    ready3_s;
   logic                    v1_r;
   logic signed [IN_W-1:0]  x1_r;
   coef_t                   c1_r;
   logic signed [SUM_W-1:0] x_ext_s;
   logic signed [SUM_W-1:0] term_s [NP];
   logic signed [SUM_W-1:0] sum_s;
   logic                    v2_r;
   logic signed [SUM_W-1:0] sum2_r;
   logic signed [MAXW-1:0]  sum_ext_s;
   rs_t                     rs_s;

   // Backpressure chain: a stage may load when it is empty or its successor moves.
   always_comb begin
      ready3_s = !out_valid | out_ready;
      ready2_s = !v2_r | ready3_s;
      ready1_s = !v1_r | ready2_s;
      in_ready = ready1_s;
   end

   // Widen the programming inputs to the package mask pair.
   always_comb begin
      coef_wr_s = '{pos: MAX_TERMS'(cfg_pos), neg: MAX_TERMS'(cfg_neg)};
   end

   // Coefficient register; a write becomes visible to the next accepted sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         coef_r <= COEF_RST;
      end else if (cfg_we) begin
         coef_r <= coef_wr_s;
      end
   end

   // S1: capture the sample together with the coefficient in force at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r <= 1'b0;
         x1_r <= '0;
         c1_r <= '0;
      end else if (ready1_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            x1_r <= in_data;
            c1_r <= coef_r;
         end
      end
   end

   // Keep MAX_SHIFT fractional bits so every shifted term is exact.
   always_comb begin
      x_ext_s = {{(SUM_W-IN_W-MAX_SHIFT){x1_r[IN_W-1]}}, x1_r, {MAX_SHIFT{1'b0}}};
   end

   for (genvar k = 0; k < NP; k++) begin : g_term
      if (k < MAX_SHIFT) begin : g_act
         shift_term #(
            .SUM_W (SUM_W),
            .K     (k + 1)
         ) u_term (
            .x_ext (x_ext_s),
            .pos   (c1_r.pos[k]),
            .neg   (c1_r.neg[k]),
            .term  (term_s[k])
         );
      end else begin : g_pad
         assign term_s[k] = '0;
      end
   end

   // Pair-wise adder tree over the (power-of-two padded) term list.
   always_comb begin
      logic signed [SUM_W-1:0] tree_v [NP];
      for (int i = 0; i < NP; i++) begin
         tree_v[i] = term_s[i];
      end
      for (int w = NP / 2; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            tree_v[i] = tree_v[2*i] + tree_v[2*i+1];
         end
      end
      sum_s = tree_v[0];
   end

   // S2: register the exact fixed-point sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r   <= 1'b0;
         sum2_r <= '0;
      end else if (ready2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            sum2_r <= sum_s;
         end
      end
   end

   // Round half toward +inf and clip to the output range.
   always_comb begin
      sum_ext_s = {{(MAXW-SUM_W){sum2_r[SUM_W-1]}}, sum2_r};
      rs_s      = round_sat(sum_ext_s, MAX_SHIFT, OUT_W);
   end

   // S3: registered result; held unchanged while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (ready3_s) begin
         out_valid <= v2_r;
         if (v2_r) begin
            out_data <= rs_s.data[OUT_W-1:0];
            out_sat  <= rs_s.sat;
         end
      end
   end

   // Mask bits above MAX_SHIFT and result bits above OUT_W are intentionally dropped.
   logic unused_s;
   if (MAX_SHIFT < MAX_TERMS) begin : g_unused_part
      assign unused_s = ^{c1_r.pos[MAX_TERMS-1:MAX_SHIFT], c1_r.neg[MAX_TERMS-1:MAX_SHIFT],
                          rs_s.data[MAXW-1:OUT_W]};
   end else begin : g_unused_full
      assign unused_s = ^rs_s.data[MAXW-1:OUT_W];
   end

endmodule

// File: tb/tb_shift_add_scaler.sv
// Directed bench for shift_add_scaler: a default 33-bit instance and a
// 16-bit-output instance share all inputs; expected values are hand-computed.
module tb_shift_add_scaler;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_we = 1'b0;
   logic [7:0]         cfg_pos = 8'h00;
   logic [7:0]         cfg_neg = 8'h00;
   logic               in_valid = 1'b0;
   logic signed [32:0] in_data = '0;
   logic               out_ready = 1'b1;
   logic               in_ready;
   logic               out_valid;
   logic signed [32:0] out_data;
   logic               out_sat;
   logic               in_ready16;
   logic               out_valid16;
   logic signed [15:0] out_data16;
   logic               out_sat16;

   int n_checks = 0;
   int n_fail   = 0;

   shift_add_scaler dut (
      .clk (clk), .rst (rst), .cfg_we (cfg_we), .cfg_pos (cfg_pos), .cfg_neg (cfg_neg),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_sat (out_sat)
   );

   shift_add_scaler #(.IN_W(33), .OUT_W(16)) dut16 (
      .clk (clk), .rst (rst), .cfg_we (cfg_we), .cfg_pos (cfg_pos), .cfg_neg (cfg_neg),
      .in_valid (in_valid), .in_ready (in_ready16), .in_data (in_data),
      .out_valid (out_valid16), .out_ready (out_ready), .out_data (out_data16), .out_sat (out_sat16)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [7:0] p, input logic [7:0] n);
      cfg_pos = p;
      cfg_neg = n;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
   endtask

   // One sample through an idle pipeline; result must appear 3 cycles after acceptance.
   task automatic run_one(input string tag, input longint d, input longint e, input longint es,
                          input longint e16, input longint es16);
      longint dv;
      dv       = d;
      in_valid = 1'b1;
      in_data  = dv[32:0];
      #1;
      check_val({tag, "_in_ready"}, longint'(in_ready), 64'sd1);
      tick();
      in_valid = 1'b0;
      check_val({tag, "_early1"}, longint'(out_valid), 64'sd0);
      tick();
      check_val({tag, "_early2"}, longint'(out_valid), 64'sd0);
      tick();
      check_val({tag, "_valid"}, longint'(out_valid), 64'sd1);
      check_val({tag, "_data"}, longint'(out_data), e);
      check_val({tag, "_sat"}, longint'(out_sat), es);
      check_val({tag, "_valid16"}, longint'(out_valid16), 64'sd1);
      check_val({tag, "_data16"}, longint'(out_data16), e16);
      check_val({tag, "_sat16"}, longint'(out_sat16), es16);
      tick();
   endtask

   initial begin
      longint exp_q[$];
      longint held;
      longint dv;
      int     sent;
      int     rx;
      int     extra;
      bit     holding;
      bit     saw_block;

      // Reset state
      tick();
      tick();
      check_val("rst_out_valid", longint'(out_valid), 64'sd0);
      check_val("rst_out_data", longint'(out_data), 64'sd0);
      check_val("rst_out_sat", longint'(out_sat), 64'sd0);
      rst = 1'b0;
      #1;
      check_val("rst_in_ready", longint'(in_ready), 64'sd1);

      // Reset coefficient 0.40625
      run_one("rst_coef_p1000", 64'sd1000, 64'sd406, 64'sd0, 64'sd406, 64'sd0);
      run_one("rst_coef_m1000", -64'sd1000, -64'sd406, 64'sd0, -64'sd406, 64'sd0);

      // 0.25: ties go toward +inf
      write_cfg(8'h02, 8'h00);
      run_one("q_p2", 64'sd2, 64'sd1, 64'sd0, 64'sd1, 64'sd0);
      run_one("q_m2", -64'sd2, 64'sd0, 64'sd0, 64'sd0, 64'sd0);

      // 0.5: 2^19 fits 33 bits but clips in 16 bits
      write_cfg(8'h01, 8'h00);
      run_one("sat_pos", 64'sd1048576, 64'sd524288, 64'sd0, 64'sd32767, 64'sd1);
      run_one("sat_neg", -64'sd1048576, -64'sd524288, 64'sd0, -64'sd32768, 64'sd1);

      // 0.5 - 0.125 and cancelling masks
      write_cfg(8'h01, 8'h04);
      run_one("mix_800", 64'sd800, 64'sd300, 64'sd0, 64'sd300, 64'sd0);
      write_cfg(8'h01, 8'h01);
      run_one("cancel_800", 64'sd800, 64'sd0, 64'sd0, 64'sd0, 64'sd0);

      // Smallest and largest terms
      write_cfg(8'h80, 8'h00);
      run_one("lsb_p128", 64'sd128, 64'sd1, 64'sd0, 64'sd1, 64'sd0);
      run_one("lsb_m128", -64'sd128, 64'sd0, 64'sd0, 64'sd0, 64'sd0);
      run_one("lsb_m129", -64'sd129, -64'sd1, 64'sd0, -64'sd1, 64'sd0);
      write_cfg(8'hFF, 8'h00);
      run_one("full_256", 64'sd256, 64'sd255, 64'sd0, 64'sd255, 64'sd0);

      // Stream of 10 with a downstream stall in cycles 4..7
      write_cfg(8'h01, 8'h00);
      sent      = 0;
      rx        = 0;
      extra     = 0;
      holding   = 1'b0;
      saw_block = 1'b0;
      held      = 0;
      for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
         dv        = 64'sd10 * longint'(sent + 1);
         in_valid  = (sent < 10);
         in_data   = dv[32:0];
         out_ready = !(cyc >= 4 && cyc <= 7);
         #1;
         if (holding) begin
            check_val("stall_hold", longint'(out_data), held);
         end
         if (in_valid && !in_ready) begin
            saw_block = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() != 0) begin
               check_val($sformatf("stream_%0d", rx), longint'(out_data), exp_q.pop_front());
            end else begin
               extra++;
            end
            rx++;
         end
         holding = out_valid && !out_ready;
         held    = longint'(out_data);
         if (in_valid && in_ready) begin
            exp_q.push_back(64'sd5 * longint'(sent + 1));
            sent++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_val("stream_rx", longint'(rx), 64'sd10);
      check_val("stream_extra", longint'(extra), 64'sd0);
      check_val("stream_backpressure", longint'(saw_block), 64'sd1);
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) begin
            extra++;
         end
         tick();
      end
      check_val("stream_drain_dup", longint'(extra), 64'sd0);

      // cfg write coinciding with acceptance: current coefficient 0.5, new 0.25
      in_valid = 1'b1;
      in_data  = 33'sd100;
      cfg_pos  = 8'h02;
      cfg_neg  = 8'h00;
      cfg_we   = 1'b1;
      tick();
      cfg_we   = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      check_val("cfgwe_old_valid", longint'(out_valid), 64'sd1);
      check_val("cfgwe_old_data", longint'(out_data), 64'sd50);
      tick();
      check_val("cfgwe_new_valid", longint'(out_valid), 64'sd1);
      check_val("cfgwe_new_data", longint'(out_data), 64'sd25);
      tick();

      // Reset with the pipeline full and stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 33'sd4000;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      #1;
      check_val("full_out_valid", longint'(out_valid), 64'sd1);
      check_val("full_in_ready", longint'(in_ready), 64'sd0);
      rst = 1'b1;
      tick();
      check_val("midrst_out_valid", longint'(out_valid), 64'sd0);
      check_val("midrst_out_data", longint'(out_data), 64'sd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      extra     = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) begin
            extra++;
         end
         tick();
      end
      check_val("midrst_no_emit", longint'(extra), 64'sd0);
      run_one("midrst_coef", 64'sd1000, 64'sd406, 64'sd0, 64'sd406, 64'sd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
